// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the multi-channel key front end.
// - key_state_e: per-channel debounce FSM states.
// - tick_div():  clock cycles per 1 ms prescaler tick.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_e;

    function automatic int unsigned tick_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/key_scan_ch.sv
// key_scan_ch: one key channel. Synchronises the raw pin, debounces press and
// release against the shared 1 ms tick and produces registered level/pulses.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   tick         one-cycle 1 ms strobe from the shared prescaler
//   key_in       raw asynchronous key pin
//   key_level    debounced state, 1 = pressed
//   key_flag     1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse, once per hold, when the hold reaches LONG_MS
module key_scan_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_flag,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CW = $clog2(LONG_MS + 1);
    localparam int unsigned RW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] C_DB   = CW'(DEBOUNCE_MS);
    localparam logic [CW-1:0] C_LONG = CW'(LONG_MS);
    localparam logic [RW-1:0] R_DB   = RW'(DEBOUNCE_MS);
    localparam logic IDLE_LVL        = (ACTIVE_LOW != 0);

    logic [1:0]    r_sync;
    logic          w_raw_p;
    key_state_e    r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [RW-1:0] r_rcnt, w_rcnt_d;
    logic          r_level, w_level_d;
    logic          r_flag, w_flag_d;
    logic          r_release, w_release_d;
    logic          r_long, w_long_d;

    // Two-flop synchroniser, parked at the released pin level during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {2{IDLE_LVL}};
        end else begin
            r_sync <= {r_sync[0], key_in};
        end
    end

    // Normalise to 1 = pressed regardless of pin polarity.
    assign w_raw_p = r_sync[1] ^ IDLE_LVL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rcnt    <= '0;
            r_level   <= 1'b0;
            r_flag    <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_rcnt    <= w_rcnt_d;
            r_level   <= w_level_d;
            r_flag    <= w_flag_d;
            r_release <= w_release_d;
            r_long    <= w_long_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_rcnt_d    = r_rcnt;
        w_level_d   = r_level;
        w_flag_d    = 1'b0;
        w_release_d = 1'b0;
        w_long_d    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_raw_p) begin
                    w_state_d = PRESS_DB;
                    w_cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!w_raw_p) begin
                    w_state_d = IDLE;
                end else if (tick) begin
                    if (r_cnt + 1'b1 == C_DB) begin
                        w_state_d = HELD;
                        w_flag_d  = 1'b1;
                        w_level_d = 1'b1;
                        w_cnt_d   = C_DB;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!w_raw_p) begin
                    w_state_d = RELEASE_DB;
                    w_rcnt_d  = '0;
                end else if (tick && (r_cnt != C_LONG)) begin
                    // Saturating: key_long can only fire on the one step into LONG_MS.
                    w_cnt_d  = r_cnt + 1'b1;
                    w_long_d = (r_cnt + 1'b1 == C_LONG);
                end
            end
            RELEASE_DB: begin
                // cnt is frozen here so a recovered glitch resumes the hold count.
                if (w_raw_p) begin
                    w_state_d = HELD;
                end else if (tick) begin
                    if (r_rcnt + 1'b1 == R_DB) begin
                        w_state_d   = IDLE;
                        w_release_d = 1'b1;
                        w_level_d   = 1'b0;
                        w_cnt_d     = '0;
                        w_rcnt_d    = '0;
                    end else begin
                        w_rcnt_d = r_rcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign key_level   = r_level;
    assign key_flag    = r_flag;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule

// File: rtl/key_scan_multi.sv
// key_scan_multi: N_KEYS independent debounced key channels sharing one 1 ms
// prescaler.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   key_in       raw key pins (asynchronous)
//   key_level    debounced state per key, 1 = pressed
//   key_flag     1-cycle pulse per accepted press
//   key_release  1-cycle pulse per accepted release
//   key_long     1-cycle pulse per hold reaching LONG_MS
module key_scan_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS      = 7,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_flag,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
    localparam int unsigned DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    if (N_KEYS < 1) begin : g_err_nkeys
        $error("key_scan_multi: N_KEYS must be >= 1");
    end
    if (TICK_DIV < 2) begin : g_err_tickdiv
        $error("key_scan_multi: CLK_HZ/1000 must be >= 2");
    end
    if (DEBOUNCE_MS < 1) begin : g_err_db
        $error("key_scan_multi: DEBOUNCE_MS must be >= 1");
    end
    if (LONG_MS <= DEBOUNCE_MS) begin : g_err_long
        $error("key_scan_multi: LONG_MS must exceed DEBOUNCE_MS");
    end
    if (ACTIVE_LOW > 1) begin : g_err_pol
        $error("key_scan_multi: ACTIVE_LOW must be 0 or 1");
    end

    logic [DW-1:0] r_div;
    logic          w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_scan_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (w_tick),
            .key_in      (key_in[g]),
            .key_level   (key_level[g]),
            .key_flag    (key_flag[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_scan_multi.sv
// Bench for key_scan_multi: directed test-plan scenarios plus random key
// activity, with every cycle compared against a streak-counting reference model.
module tb_key_scan_multi;

    localparam int unsigned N    = 4;
    localparam int unsigned CLKH = 10_000;
    localparam int unsigned DB   = 3;
    localparam int unsigned LONG = 10;
    localparam int unsigned TDIV = CLKH / 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] key_level, key_flag, key_release, key_long;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_scan_multi #(
        .N_KEYS      (N),
        .CLK_HZ      (CLKH),
        .DEBOUNCE_MS (DB),
        .LONG_MS     (LONG),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_flag    (key_flag),
        .key_release (key_release),
        .key_long    (key_long)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history delayed two samples, then per key an accepted
    // level plus a count of ms ticks the opposite level has persisted, and a
    // count of ms ticks the press has been held.
    bit           m_d0 [N];
    bit           m_d1 [N];
    bit           m_lvl[N];
    bit           m_pend[N];
    int           m_streak[N];
    int           m_hold[N];
    longint       m_edges = 0;
    logic [N-1:0] m_flag = '0, m_rel = '0, m_long = '0, m_level = '0;

    task automatic model_step(input logic [N-1:0] kin, input bit rst_v);
        bit tk;
        bit p;
        m_flag = '0;
        m_rel  = '0;
        m_long = '0;
        if (!rst_v) begin
            m_edges = 0;
            for (int i = 0; i < N; i++) begin
                m_d0[i] = 1'b1; m_d1[i] = 1'b1; m_lvl[i] = 1'b0; m_pend[i] = 1'b0;
                m_streak[i] = 0; m_hold[i] = 0;
            end
        end else begin
            tk = ((m_edges % TDIV) == TDIV - 1);
            m_edges++;
            for (int i = 0; i < N; i++) begin
                p = !m_d1[i];
                m_d1[i] = m_d0[i];
                m_d0[i] = kin[i];
                if (p != m_lvl[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i]   = 1'b1;   // streak starts; this cycle's tick ignored
                        m_streak[i] = 0;
                    end else if (tk) begin
                        m_streak[i]++;
                        if (m_streak[i] == DB) begin
                            m_pend[i] = 1'b0;
                            m_lvl[i]  = p;
                            if (p) begin
                                m_flag[i] = 1'b1;
                                m_hold[i] = DB;
                            end else begin
                                m_rel[i] = 1'b1;
                            end
                        end
                    end
                end else begin
                    m_pend[i] = 1'b0;
                    if (m_lvl[i] && tk && m_hold[i] < LONG) begin
                        m_hold[i]++;
                        if (m_hold[i] == LONG) m_long[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) m_level[i] = m_lvl[i];
    endtask

    // Per-cycle monitor: model compare plus pulse bookkeeping.
    int cyc = 0;
    int n_flag[N], n_rel[N], n_long[N], t_flag[N], t_long[N];
    bit lvl_seen[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            n_flag[i] = 0; n_rel[i] = 0; n_long[i] = 0;
            t_flag[i] = 0; t_long[i] = 0; lvl_seen[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [N-1:0] kin_s;
        bit           rst_s;
        kin_s = key_in;
        rst_s = rst;
        #2;
        cyc++;
        model_step(kin_s, rst_s);
        check("model", 32'({key_level, key_flag, key_release, key_long}),
              32'({m_level, m_flag, m_rel, m_long}));
        for (int i = 0; i < N; i++) begin
            if (key_flag[i]) begin n_flag[i]++; t_flag[i] = cyc; end
            if (key_long[i]) begin n_long[i]++; t_long[i] = cyc; end
            if (key_release[i]) n_rel[i]++;
            if (key_level[i]) lvl_seen[i] = 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges from now until the pulse selected by 'which' appears on key k.
    task automatic wait_pulse(input int k, input int which, output int lat);
        lat = 60;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #3;
            if ((which == 0 && key_flag[k]) || (which == 1 && key_release[k])) begin
                lat = n;
                break;
            end
        end
        @(negedge clk);
    endtask

    function automatic int clampw(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    int lat;
    int f0, r0, l0;
    int snap_rel;

    initial begin
        // Reset with all pins low (pressed): outputs must stay 0.
        rst    = 1'b0;
        key_in = '0;
        cycles(5);
        check("reset_outputs", 32'({key_level, key_flag, key_release, key_long}), 32'h0);

        key_in = '1;
        cycles(1);
        rst = 1'b1;
        cycles(200);
        for (int i = 0; i < N; i++) begin
            check("idle_flags", 32'(n_flag[i] + n_rel[i] + n_long[i]), 32'h0);
            check("idle_level", 32'(lvl_seen[i]), 32'h0);
        end

        // Clean press on key 0.
        key_in[0] = 1'b0;
        wait_pulse(0, 0, lat);
        check("press0_latency", 32'(lat), 32'(clampw(lat, 21, 34)));
        check("press0_level", 32'(key_level[0]), 32'h1);
        check("press0_others", 32'(key_level[3:1]), 32'h0);
        key_in[0] = 1'b1;
        cycles(40);

        // Bounce on key 1: 7-cycle toggles never survive a debounce window.
        lvl_seen[1] = 1'b0;
        f0 = n_flag[1];
        r0 = n_rel[1];
        for (int i = 0; i < 14; i++) begin
            key_in[1] = ~key_in[1];
            cycles(7);
        end
        key_in[1] = 1'b1;
        cycles(50);
        check("bounce_flag", 32'(n_flag[1] - f0), 32'h0);
        check("bounce_rel", 32'(n_rel[1] - r0), 32'h0);
        check("bounce_level", 32'(lvl_seen[1]), 32'h0);

        // Long press then release on key 2.
        f0 = n_flag[2]; r0 = n_rel[2]; l0 = n_long[2];
        key_in[2] = 1'b0;
        cycles(150);
        key_in[2] = 1'b1;
        wait_pulse(2, 1, lat);
        check("long2_flag_cnt", 32'(n_flag[2] - f0), 32'h1);
        check("long2_long_cnt", 32'(n_long[2] - l0), 32'h1);
        check("long2_rel_cnt", 32'(n_rel[2] - r0), 32'h1);
        check("long2_gap", 32'(t_long[2] - t_flag[2]),
              32'(clampw(t_long[2] - t_flag[2], 60, 80)));
        check("long2_rel_latency", 32'(lat), 32'(clampw(lat, 21, 34)));
        cycles(20);

        // Release glitch on key 3 while held.
        f0 = n_flag[3]; r0 = n_rel[3];
        key_in[3] = 1'b0;
        cycles(45);
        key_in[3] = 1'b1;
        cycles(5);
        key_in[3] = 1'b0;
        cycles(40);
        check("glitch3_flag", 32'(n_flag[3] - f0), 32'h1);
        check("glitch3_rel", 32'(n_rel[3] - r0), 32'h0);
        check("glitch3_level", 32'(key_level[3]), 32'h1);
        key_in[3] = 1'b1;
        cycles(50);

        // Random activity: keys 0/1 bouncy, keys 2/3 slow.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, (i < 2) ? 7 : 39) == 0) key_in[i] = ~key_in[i];
            end
            cycles(1);
        end
        key_in = '1;
        cycles(60);
        check("random_settled", 32'(key_level), 32'h0);

        // Simultaneous press on all keys, then reset mid-hold.
        key_in = '0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #3;
            if (key_flag != '0) begin
                lat = n;
                break;
            end
        end
        check("simul_flags", 32'(key_flag), 32'hF);
        check("simul_latency", 32'(lat), 32'(clampw(lat, 21, 34)));
        cycles(20);
        check("simul_held", 32'(key_level), 32'hF);
        snap_rel = 0;
        for (int i = 0; i < N; i++) snap_rel += n_rel[i];
        rst = 1'b0;
        #1;
        check("rst_mid_level", 32'(key_level), 32'h0);
        check("rst_mid_pulses", 32'({key_flag, key_release, key_long}), 32'h0);
        cycles(3);
        key_in = '1;
        rst    = 1'b1;
        cycles(60);
        for (int i = 0; i < N; i++) snap_rel -= n_rel[i];
        check("rst_mid_no_release", 32'(snap_rel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scan_multi.md
# key_scan_multi

Parametrised multi-channel key front end: the next generation of the per-key debouncer array, with N_KEYS channels in one instance. Each channel synchronises its raw key input, debounces press and release against a shared 1 ms tick, and reports a debounced level plus press, release and long-press pulses. The block sits between the board key pins and the control logic. `key_flag` keeps its existing meaning: one-cycle pulse per debounced press.

## Interface
- `N_KEYS`, 7, number of key channels (≥1)
- `CLK_HZ`, 50_000_000, clock frequency; `TICK_DIV = CLK_HZ/1000` must be ≥2
- `DEBOUNCE_MS`, 20, stable time in ticks required to accept a press or a release (≥1)
- `LONG_MS`, 1000, held time in ticks before `key_long` fires (>`DEBOUNCE_MS`)
- `ACTIVE_LOW`, 1, 1 = raw key reads 0 when pressed
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `key_in`  in  N_KEYS  raw key pins, asynchronous
- `key_level`  out  N_KEYS  debounced state, 1 = pressed
- `key_flag`  out  N_KEYS  1-cycle pulse on accepted press
- `key_release`  out  N_KEYS  1-cycle pulse on accepted release
- `key_long`  out  N_KEYS  1-cycle pulse, once per hold, at LONG_MS

## Operation
- Shared prescaler counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when count = TICK_DIV-1. Reset clears it to 0.
- Per channel, a 2-flop synchroniser is reset to the idle level (1 if ACTIVE_LOW, else 0). `raw_p` is the synchronised level converted to 1 = pressed.
- Per-channel FSM, with counter `cnt` of width $clog2(LONG_MS+1) that saturates and never wraps:
  - IDLE: if `raw_p`, go to PRESS_DB and set cnt=0.
  - PRESS_DB: if `!raw_p`, return to IDLE with no output. Else cnt+1 on each tick. When cnt reaches DEBOUNCE_MS, go to HELD, pulse `key_flag`, set `key_level`=1, set cnt=DEBOUNCE_MS.
  - HELD: cnt+1 on each tick, saturating at LONG_MS. On the transition to LONG_MS, pulse `key_long` once. If `!raw_p`, go to RELEASE_DB and clear the release counter `rcnt`, which has width $clog2(DEBOUNCE_MS+1).
  - RELEASE_DB: if `raw_p`, return to HELD with cnt preserved. cnt is frozen while in RELEASE_DB. Else rcnt+1 on each tick. When rcnt reaches DEBOUNCE_MS, go to IDLE, pulse `key_release`, set `key_level`=0.
- Channels are fully independent. Simultaneous presses on any subset of keys each produce their own pulses in the same cycle.
- Bounces shorter than the debounce window produce no pulse and no level change.
- `key_long` fires at most once per accepted press.
- A release inside the window that then recovers does not re-fire `key_flag` or `key_long`.

## Timing
- Reset (async assert, sync release): all FSMs go to IDLE, counters to 0, all outputs 0.
- Reset mid-hold drops `key_level` immediately, with no `key_release` pulse.
- Pulse outputs and `key_level` are registered.
- Input-to-FSM latency: 2 cycles through the synchroniser, plus 1 cycle to the state register.
- Accept latency after a stable edge reaches the FSM: between (DEBOUNCE_MS-1)·TICK_DIV+1 and DEBOUNCE_MS·TICK_DIV+1 cycles. The spread comes from tick phase.
- `key_long` occurs LONG_MS-DEBOUNCE_MS ticks after `key_flag`, ±1 tick.
- A tick arriving in the same cycle as a state entry is not counted. Counting starts from the next tick.

## Structure
- Package `key_pkg`: FSM state enum (IDLE, PRESS_DB, HELD, RELEASE_DB) and the helper `TICK_DIV` calculation.
- The top holds the prescaler and a generate loop over N_KEYS.
- Sub-module `key_scan_ch`: one channel (synchroniser, FSM, counters, outputs). It takes `tick` as an input.
- Elaboration-time checks on the parameter constraints listed under Interface.

## Test plan
Setup: CLK_HZ=10_000 (TICK_DIV=10), DEBOUNCE_MS=3, LONG_MS=10, N_KEYS=4, ACTIVE_LOW=1.
- Reset: hold `rst`=0 with `key_in`=4'b0000. Required: all outputs 0. Release reset with keys high: outputs stay 0 for 200 cycles.
- Clean press: drive `key_in[0]`=0 and hold. Required: one `key_flag[0]` pulse within 21–34 cycles, `key_level[0]`=1, and no activity on other channels.
- Bounce rejection: toggle `key_in[1]` every 7 cycles for 100 cycles, then leave it high. Required: no pulses and `key_level[1]`=0 throughout.
- Long press and release: hold key 2 low for 150 cycles, then high. Required, in order: `key_flag[2]`, then `key_long[2]` about 70±10 cycles later, then `key_release[2]` within 21–34 cycles of release. Each fires exactly once.
- Release glitch: while key 3 is held, pull it high for 5 cycles, then low again. Required: no `key_release[3]`, no second `key_flag[3]`, and `key_level[3]` stays 1.
- Simultaneous press, then reset mid-hold: press keys 0–3 in the same cycle. Required: all four `key_flag` pulses in the same cycle. Then assert `rst` during HELD: `key_level`=0 immediately and no `key_release`.
